// File: rtl/seq_display_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq_display_ctrl
//  Description : Timed hex-value sequencer with per-entry dwell, loop or
//                one-shot run, selectable direction, and a multiplexed
//                7-segment display that shows the most recent entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_display_ctrl #(
    parameter int                   NUM_DIGITS = 4,
    parameter int                   SEQ_LEN    = 3,
    parameter int                   STEP_DIV   = 100000000,
    parameter int                   SCAN_DIV   = 100000,
    parameter logic [4*SEQ_LEN-1:0] SEQ_VALS   = {4'h0, 4'h7, 4'h1},
    parameter logic [4*SEQ_LEN-1:0] SEQ_HOLDS  = {4'd1, 4'd1, 4'd2}
) (
    input  logic                       clk,
    input  logic                       RST_N,
    input  logic                       EIN,
    input  logic                       MODE,
    input  logic                       DIR,
    output logic [6:0]                 seg_cath,
    output logic [NUM_DIGITS-1:0]      Anode_Activate,
    output logic [$clog2(SEQ_LEN)-1:0] step_idx,
    output logic                       step_pulse,
    output logic                       done
);

    localparam int c_IDX_W = $clog2(SEQ_LEN);
    localparam int c_SDW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int c_CDW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [c_IDX_W-1:0]      c_LAST      = c_IDX_W'(SEQ_LEN - 1);
    localparam logic [c_SDW-1:0]        c_STEP_MAX  = c_SDW'(STEP_DIV - 1);
    localparam logic [c_CDW-1:0]        c_SCAN_MAX  = c_CDW'(SCAN_DIV - 1);
    localparam logic [c_SEL_W-1:0]      c_SEL_LAST  = c_SEL_W'(NUM_DIGITS - 1);
    localparam logic [4*NUM_DIGITS-1:0] c_HIST_RST  = (4*NUM_DIGITS)'(SEQ_VALS[3:0]);
    localparam logic [NUM_DIGITS-1:0]   c_VALID_RST = NUM_DIGITS'(1);

    logic [c_SDW-1:0]        r_step_div;
    logic [c_CDW-1:0]        r_scan_div;
    logic [3:0]              r_hold_cnt;
    logic [c_IDX_W-1:0]      r_step_idx;
    logic [c_SEL_W-1:0]      r_sel;
    logic                    r_done;
    logic                    r_step_pulse;
    logic                    r_dir_q;
    logic [4*NUM_DIGITS-1:0] r_hist;
    logic [NUM_DIGITS-1:0]   r_valid;
    logic [6:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_an;

    logic [3:0]              w_val_tab  [SEQ_LEN];
    logic [3:0]              w_hold_tab [SEQ_LEN];
    logic [3:0]              w_hist_tab [NUM_DIGITS];
    logic [4*NUM_DIGITS-1:0] w_hist_shift;
    logic [NUM_DIGITS-1:0]   w_valid_shift;
    logic [3:0]              w_hold_raw;
    logic [3:0]              w_hold_lim;
    logic [c_IDX_W-1:0]      w_next_idx;
    logic                    w_step_tick;
    logic                    w_scan_wrap;
    logic                    w_run_tick;
    logic                    w_expire;
    logic                    w_terminal;
    logic                    w_advance;

    // Unpack the per-entry value and dwell tables
    for (genvar i = 0; i < SEQ_LEN; i++) begin : g_tab
        assign w_val_tab[i]  = SEQ_VALS[4*i +: 4];
        assign w_hold_tab[i] = SEQ_HOLDS[4*i +: 4];
    end

    // Per-digit view of the history register for the display mux
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_htab
        assign w_hist_tab[k] = r_hist[4*k +: 4];
    end

    // History shift: newest entry enters digit 0, older entries move up
    if (NUM_DIGITS > 1) begin : g_shift_multi
        assign w_hist_shift  = {r_hist[4*NUM_DIGITS-5:0], w_val_tab[w_next_idx]};
        assign w_valid_shift = {r_valid[NUM_DIGITS-2:0], 1'b1};
    end else begin : g_shift_single
        assign w_hist_shift  = w_val_tab[w_next_idx];
        assign w_valid_shift = 1'b1;
    end

    assign w_step_tick = (r_step_div == c_STEP_MAX);
    assign w_scan_wrap = (r_scan_div == c_SCAN_MAX);
    assign w_hold_raw  = w_hold_tab[r_step_idx];
    // A programmed dwell of 0 behaves as a dwell of 1
    assign w_hold_lim  = (w_hold_raw == 4'd0) ? 4'd0 : w_hold_raw - 4'd1;
    assign w_run_tick  = w_step_tick && EIN && !r_done;
    assign w_expire    = w_run_tick && (r_hold_cnt >= w_hold_lim);
    assign w_terminal  = DIR ? (r_step_idx == '0) : (r_step_idx == c_LAST);
    // In one-shot mode the terminal entry finishes the run instead of advancing
    assign w_advance   = w_expire && !(MODE && w_terminal);

    // Neighbouring index in the selected direction, wrapping at both ends
    always_comb begin
        w_next_idx = r_step_idx;
        if (DIR) begin
            w_next_idx = (r_step_idx == '0) ? c_LAST : r_step_idx - 1'b1;
        end else begin
            w_next_idx = (r_step_idx == c_LAST) ? '0 : r_step_idx + 1'b1;
        end
    end

    // Free-running step and scan dividers plus digit select
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            r_step_div <= '0;
            r_scan_div <= '0;
            r_sel      <= '0;
        end else begin
            r_step_div <= w_step_tick ? '0 : r_step_div + 1'b1;
            if (w_scan_wrap) begin
                r_scan_div <= '0;
                r_sel      <= (r_sel == c_SEL_LAST) ? '0 : r_sel + 1'b1;
            end else begin
                r_scan_div <= r_scan_div + 1'b1;
            end
        end
    end

    // Sequencer: dwell counting, index advance, one-shot completion
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            r_hold_cnt   <= '0;
            r_step_idx   <= '0;
            r_done       <= 1'b0;
            r_step_pulse <= 1'b0;
            r_dir_q      <= DIR;
            r_hist       <= c_HIST_RST;
            r_valid      <= c_VALID_RST;
        end else begin
            r_dir_q      <= DIR;
            r_step_pulse <= w_advance;
            if (w_run_tick) begin
                r_hold_cnt <= (r_hold_cnt < w_hold_lim) ? r_hold_cnt + 4'd1 : 4'd0;
            end
            if (w_advance) begin
                r_step_idx <= w_next_idx;
                r_hist     <= w_hist_shift;
                r_valid    <= w_valid_shift;
            end
            if (w_expire && MODE && w_terminal) begin
                r_done <= 1'b1;
            end else if (!MODE || (DIR != r_dir_q)) begin
                r_done <= 1'b0;
            end
        end
    end

    // Active-low hex to 7-segment decode, bit6 = a .. bit0 = g
    function automatic logic [6:0] f_hex7(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    // Registered display drive for the currently selected digit
    always_ff @(posedge clk) begin
        if (!RST_N) begin
            r_an  <= '1;
            r_seg <= 7'b1111111;
        end else begin
            r_an  <= ~(NUM_DIGITS'(1) << r_sel);
            r_seg <= r_valid[r_sel] ? f_hex7(w_hist_tab[r_sel]) : 7'b1111111;
        end
    end

    assign seg_cath       = r_seg;
    assign Anode_Activate = r_an;
    assign step_idx       = r_step_idx;
    assign step_pulse     = r_step_pulse;
    assign done           = r_done;

endmodule
`default_nettype wire

// File: doc/seq_display_ctrl.md
SEQ_DISPLAY_CTRL -- requirements
Module: seq_display_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed 7-segment digits, legal range 1..8.
REQ-002 Parameter SEQ_LEN, default 3: number of sequence entries, legal range 2..16.
REQ-003 Parameter STEP_DIV, default 100000000: clk cycles per step tick.
REQ-004 Parameter SCAN_DIV, default 100000: clk cycles per digit-scan tick.
REQ-005 Parameter SEQ_VALS [4*SEQ_LEN-1:0], default {4'h0,4'h7,4'h1}: entry i hex value is held in bits [4i+3:4i], so entry0=1, entry1=7, entry2=0.
REQ-006 Parameter SEQ_HOLDS [4*SEQ_LEN-1:0], default {4'd1,4'd1,4'd2}: entry i dwell, in step ticks; a value of 0 is treated as 1.
REQ-007 clk  in  1  system clock; all state updates on its rising edge.
REQ-008 RST_N  in  1  reset; synchronous, active-low.
REQ-009 EIN  in  1  run enable; when low, sequencing pauses.
REQ-010 MODE  in  1  0 = loop, 1 = one-shot.
REQ-011 DIR  in  1  0 = forward (index +1), 1 = reverse (index -1).
REQ-012 seg_cath  out  7  cathodes, active-low; bit6 = a through bit0 = g.
REQ-013 Anode_Activate  out  NUM_DIGITS  anodes, active-low, with at most one bit low.
REQ-014 step_idx  out  $clog2(SEQ_LEN)  current entry index.
REQ-015 step_pulse  out  1  one-cycle pulse on each advance.
REQ-016 done  out  1  high when a one-shot run has completed.

Function
REQ-017 Step divider: counts 0..STEP_DIV-1 continuously, regardless of EIN, and produces a one-cycle tick when the count equals STEP_DIV-1.
REQ-018 Hold counter, on a tick with EIN=1 and done=0:
- if hold_cnt < hold(step_idx)-1, it increments;
- otherwise, it clears and the sequence advances.
REQ-019 With EIN=0, hold_cnt, step_idx and the history are frozen; the divider keeps running.
REQ-020 Advance target: step_idx ±1 per DIR.
- Loop mode: wraps SEQ_LEN-1→0 forward and 0→SEQ_LEN-1 reverse.
REQ-021 One-shot mode, at the terminal index (SEQ_LEN-1 forward, 0 reverse), on hold expiry:
- index does not change;
- done sets and step_pulse does not fire.
REQ-022 done clears on the cycle MODE is sampled 0 or when DIR changes; the sequence resumes from the held index on the next qualifying expiry.
REQ-023 A DIR change mid-dwell does not clear hold_cnt; the new direction applies at the next advance.
REQ-024 History register of NUM_DIGITS nibbles plus valid bits:
- on advance, hist[k] <= hist[k-1] for k ≥ 1, and hist[0] <= SEQ_VALS[new idx];
- the valid bits shift the same way, with valid[0] = 1.
REQ-025 Scan: the scan divider counts 0..SCAN_DIV-1; on each wrap, the digit select increments modulo NUM_DIGITS.
REQ-026 Display outputs are registered, with one cycle latency from digit-select/history change:
- Anode_Activate = ~(1 << sel);
- seg_cath = hex decode of hist[sel] when valid, else 7'b1111111.
REQ-027 Hex decode (active-low): 0=0000001, 1=1001111, 7=0001111; the remaining codes follow standard hex 7-segment patterns (A–F as A, b, C, d, E, F).
REQ-028 step_pulse is registered: high exactly one cycle, on the cycle after the advance tick.
REQ-029 Width rule: hold_cnt is 4 bits; all index arithmetic is modulo SEQ_LEN and never produces an out-of-range index.

Reset
REQ-030 On a clk edge with RST_N=0, the following all clear to 0: step divider, scan divider, hold_cnt, step_idx, sel, done and step_pulse.
REQ-031 On the same reset edge, hist[0] = SEQ_VALS[0] with valid[0] = 1; all other valid bits = 0.
REQ-032 During reset, Anode_Activate = all ones and seg_cath = 7'b1111111; reset mid-dwell or mid-scan aborts immediately, with no pending pulse.

Verification (STEP_DIV=4, SCAN_DIV=2, NUM_DIGITS=4, default sequence)
REQ-033 Reset release with EIN=1, loop:
- step_idx = 0 for 2 ticks, 1 for 1 tick, 2 for 1 tick, then back to 0;
- one step_pulse per advance.
REQ-034 Scan check:
- Anode_Activate cycles 1110→1101→1011→0111 every 2 clk;
- after two advances, seg_cath = 0000001 on digit 0, 0001111 on digit 1, 1001111 on digit 2, and 1111111 on digit 3.
REQ-035 EIN low for 10 ticks mid-dwell:
- step_idx, hold_cnt and history are unchanged;
- on re-assertion, the remaining dwell completes normally.
REQ-036 MODE=1, DIR=0:
- after idx 2 expires, done = 1, idx stays 2 and no step_pulse fires;
- driving MODE=0 clears done, and the next expiry wraps idx to 0.
REQ-037 DIR=1 from reset gives sequence 0→2→1→0; RST_N low for one edge mid-dwell returns idx = 0, done = 0, and history to entry0 only.
